// File: rtl/key_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
package key_cond_pkg;

    // Per-key debounce state machine.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_t;

    // Depth of the input synchroniser chain.
    localparam int SYNC_STAGES = 2;

    // Raw pin level of a key that is not pressed (buttons are active-low).
    localparam logic KEY_RELEASED_LEVEL = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a counter that must reach n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, press/release pulses and
// optional auto-repeat. All outputs are registered.
//
// Handshake note: there is no valid/ready here; every pulse output is a
// single-cycle strobe, and key_level is a level that only changes together
// with a key_press or key_release strobe in the same cycle.
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_EN            = 1,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    output logic       key_level,
    output logic       key_press,
    output logic       key_repeat,
    output logic       key_release,
    output logic [1:0] dbg_state
);

    localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam bit RPT_ON  = (REPEAT_EN != 0);

    localparam logic [DB_W-1:0]  DB_LAST         = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    key_state_t       state_q, state_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
    logic             level_d, press_d, repeat_d, release_d;
    logic [RPT_W-1:0] rpt_last;

    // Synchroniser: shift the raw pin in; resets to the released pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{KEY_RELEASED_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    // Synchronised key, 1 = pressed.
    assign s = ~sync_q[SYNC_STAGES-1];

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RELEASED;
            db_q        <= '0;
            rpt_q       <= '0;
            first_q     <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_repeat  <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_q        <= db_d;
            rpt_q       <= rpt_d;
            first_q     <= first_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_repeat  <= repeat_d;
            key_release <= release_d;
        end
    end

    // Next state, counter updates and pulse decisions for the coming edge.
    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        rpt_d     = rpt_q;
        first_d   = first_q;
        level_d   = key_level;
        press_d   = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;
        rpt_last  = first_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST;

        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_PEND;
                    db_d    = '0;
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (db_q == DB_LAST) begin
                    state_d = PRESSED;
                    db_d    = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rpt_d   = '0;
                    first_d = 1'b0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_PEND;
                    db_d    = '0;
                end
            end
            RELEASE_PEND: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (db_q == DB_LAST) begin
                    state_d   = RELEASED;
                    db_d      = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase

        // Repeat timer runs while the key is held; a release on this edge
        // takes priority and suppresses any repeat.
        if ((state_q == PRESSED) || (state_q == RELEASE_PEND)) begin
            if (release_d) begin
                rpt_d = '0;
            end else if (rpt_q == rpt_last) begin
                rpt_d    = '0;
                first_d  = 1'b1;
                repeat_d = RPT_ON;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the active-low push-buttons for the key PIO: one independent
// debounce channel per key, plus the PIO-facing inverted level and the
// combined press/repeat event strobe used for edge capture.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS             = 4,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_EN            = 1,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [NUM_KEYS-1:0]   key_n_in,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic [NUM_KEYS-1:0]   pio_keys_export,
    output logic [NUM_KEYS-1:0]   key_press,
    output logic [NUM_KEYS-1:0]   key_repeat,
    output logic [NUM_KEYS-1:0]   key_release,
    output logic [NUM_KEYS-1:0]   key_event,
    output logic [2*NUM_KEYS-1:0] dbg_state
);

    // One fully independent channel per key.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_EN            (REPEAT_EN),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
        ) u_ch (
            .clk         (clk_clk),
            .rst         (reset_reset),
            .key_n       (key_n_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_repeat  (key_repeat[i]),
            .key_release (key_release[i]),
            .dbg_state   (dbg_state[2*i +: 2])
        );
    end

    // Software reads clean active-low levels; edge capture sees presses and repeats.
    assign pio_keys_export = ~key_level;
    assign key_event       = key_press | key_repeat;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: a debounce/repeat reference model driven by the
// same raw key waveform, plus scenario checks against fixed edge numbers.
module tb_key_conditioner;

    localparam int NK  = 4;
    localparam int D   = 8;
    localparam int RD  = 40;
    localparam int RP  = 16;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic [NK-1:0] key_n_in;
    logic [NK-1:0] key_n_nr;

    logic [NK-1:0]   key_level, pio_keys_export, key_press, key_repeat, key_release, key_event;
    logic [2*NK-1:0] dbg_state;
    logic [NK-1:0]   nr_level, nr_pio, nr_press, nr_repeat, nr_release, nr_event;
    logic [2*NK-1:0] nr_dbg_state;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk_clk = ~clk_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
        .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .key_n_in(key_n_in),
        .key_level(key_level), .pio_keys_export(pio_keys_export),
        .key_press(key_press), .key_repeat(key_repeat), .key_release(key_release),
        .key_event(key_event), .dbg_state(dbg_state)
    );

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
        .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
    ) dut_nr (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .key_n_in(key_n_nr),
        .key_level(nr_level), .pio_keys_export(nr_pio),
        .key_press(nr_press), .key_repeat(nr_repeat), .key_release(nr_release),
        .key_event(nr_event), .dbg_state(nr_dbg_state)
    );

    logic [23:0] obs0, obs1;
    assign obs0 = {key_level, key_press, key_repeat, key_release, key_event, pio_keys_export};
    assign obs1 = {nr_level, nr_press, nr_repeat, nr_release, nr_event, nr_pio};

    // ---------------- reference model ----------------
    // Per key: the raw level seen two edges late; the debounced level flips
    // once the late-seen level has disagreed with it for D+1 consecutive edges.
    // While pressed, repeats fall RD edges after the press, then every RP.
    bit   m_h1 [2][NK];
    bit   m_h2 [2][NK];
    bit   m_lvl[2][NK];
    int   m_run[2][NK];
    int   m_age[2][NK];
    int   m_thr[2][NK];
    logic [NK-1:0] e_press[2];
    logic [NK-1:0] e_rpt[2];
    logic [NK-1:0] e_rel[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            e_press[i] = '0;
            e_rpt[i]   = '0;
            e_rel[i]   = '0;
            for (int k = 0; k < NK; k++) begin
                m_h1[i][k]  = 1'b0;
                m_h2[i][k]  = 1'b0;
                m_lvl[i][k] = 1'b0;
                m_run[i][k] = 0;
                m_age[i][k] = 0;
                m_thr[i][k] = RD;
            end
        end
    endtask

    task automatic model_step();
        bit s;
        bit kn;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NK; k++) begin
                kn = (i == 0) ? key_n_in[k] : key_n_nr[k];
                s = m_h2[i][k];
                m_h2[i][k] = m_h1[i][k];
                m_h1[i][k] = ~kn;
                e_press[i][k] = 1'b0;
                e_rpt[i][k]   = 1'b0;
                e_rel[i][k]   = 1'b0;
                if (s != m_lvl[i][k]) m_run[i][k]++;
                else m_run[i][k] = 0;
                if (m_run[i][k] == D + 1) begin
                    m_run[i][k] = 0;
                    if (!m_lvl[i][k]) begin
                        m_lvl[i][k]   = 1'b1;
                        e_press[i][k] = 1'b1;
                        m_age[i][k]   = 0;
                        m_thr[i][k]   = RD;
                    end else begin
                        m_lvl[i][k] = 1'b0;
                        e_rel[i][k] = 1'b1;
                    end
                end else if (m_lvl[i][k] && i == 0) begin
                    m_age[i][k]++;
                    if (m_age[i][k] == m_thr[i][k]) begin
                        e_rpt[i][k] = 1'b1;
                        m_age[i][k] = 0;
                        m_thr[i][k] = RP;
                    end
                end
            end
        end
    endtask

    function automatic logic [23:0] exp_vec(input int i);
        logic [NK-1:0] lv;
        for (int k = 0; k < NK; k++) lv[k] = m_lvl[i][k];
        return {lv, e_press[i], e_rpt[i], e_rel[i], e_press[i] | e_rpt[i], ~lv};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_clk);
        model_step();
        #1;
    endtask

    task automatic settle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_reset = 1'b1;
        key_n_in = '1;
        key_n_nr = '1;
        model_reset();
        repeat (3) @(posedge clk_clk);
        #1;
        total++;
        if (obs0 !== 24'h00000F) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs0, 24'h00000F);
        end
        total++;
        if (obs1 !== 24'h00000F) begin
            bad++;
            $display("FAIL reset_outputs_nr got=%h want=%h", obs1, 24'h00000F);
        end
        @(negedge clk_clk);
        reset_reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL idle c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
        end
    endtask

    task automatic test_clean_press();
        int press_at = -1, rel_at = -1, npress = 0, nrpt = 0, nrel = 0;
        key_n_in = 4'b1110;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL clean_press c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (key_press[0]) begin
                npress++;
                press_at = c;
                total++;
                if (pio_keys_export !== 4'b1110) begin
                    bad++;
                    $display("FAIL clean_pio got=%b want=1110", pio_keys_export);
                end
            end
            if (key_repeat[0]) nrpt++;
        end
        key_n_in = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL clean_release c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (key_release[0]) begin
                nrel++;
                rel_at = c;
            end
        end
        total++;
        if (press_at !== 10 || npress !== 1) begin
            bad++;
            $display("FAIL clean_press_edge got=%0d n=%0d want=10 n=1", press_at, npress);
        end
        total++;
        if (nrpt !== 0) begin
            bad++;
            $display("FAIL clean_no_repeat got=%0d want=0", nrpt);
        end
        total++;
        if (rel_at !== 10 || nrel !== 1) begin
            bad++;
            $display("FAIL clean_release_edge got=%0d n=%0d want=10 n=1", rel_at, nrel);
        end
    endtask

    task automatic test_bounce();
        int press_at = -1, npress = 0, nrel = 0;
        for (int c = 0; c < 60; c++) begin
            key_n_in[1] = (c < 30) ? (((c / 3) % 2) != 0) : 1'b0;
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL bounce c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (key_press[1]) begin
                npress++;
                press_at = c;
            end
            if (key_release != '0) nrel++;
        end
        total++;
        if (press_at !== 40 || npress !== 1) begin
            bad++;
            $display("FAIL bounce_press got=%0d n=%0d want=40 n=1", press_at, npress);
        end
        total++;
        if (nrel !== 0) begin
            bad++;
            $display("FAIL bounce_release got=%0d want=0", nrel);
        end
        key_n_in = '1;
        settle(20);
    endtask

    // Holds key k for 100 cycles, optionally with a 5-cycle release glitch,
    // and checks press at 10 and repeats at 50/66/82/98.
    task automatic test_hold(input int k, input bit glitch);
        int exp_r[4] = '{50, 66, 82, 98};
        int rq[$];
        int eq[$];
        int press_at = -1, npress = 0, nrel = 0, low_after = 0;
        for (int c = 0; c < 100; c++) begin
            key_n_in[k] = glitch && (c >= 30) && (c < 35);
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL hold k=%0d c=%0d got=%h want=%h", k, c, obs0, exp_vec(0));
            end
            if (key_press[k]) begin
                npress++;
                press_at = c;
            end
            if (key_repeat[k]) rq.push_back(c);
            if (key_event[k]) eq.push_back(c);
            if (key_release[k]) nrel++;
            if (c >= 10 && !key_level[k]) low_after++;
        end
        total++;
        if (press_at !== 10 || npress !== 1) begin
            bad++;
            $display("FAIL hold_press k=%0d got=%0d n=%0d want=10 n=1", k, press_at, npress);
        end
        total++;
        if (rq.size() !== 4) begin
            bad++;
            $display("FAIL hold_repeat_count k=%0d got=%0d want=4", k, rq.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (rq[j] !== exp_r[j]) begin
                    bad++;
                    $display("FAIL hold_repeat_edge k=%0d j=%0d got=%0d want=%0d", k, j, rq[j], exp_r[j]);
                end
            end
        end
        total++;
        if (eq.size() !== 5 || eq[0] !== 10) begin
            bad++;
            $display("FAIL hold_event k=%0d count=%0d want=5", k, eq.size());
        end
        total++;
        if (nrel !== 0 || low_after !== 0) begin
            bad++;
            $display("FAIL hold_level k=%0d releases=%0d low_cycles=%0d want=0,0", k, nrel, low_after);
        end
        key_n_in = '1;
        settle(20);
    endtask

    task automatic test_simul_reset();
        logic [NK-1:0] pv = '0;
        key_n_in = 4'b1010;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL simul c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (c == 10) pv = key_press;
        end
        total++;
        if (pv !== 4'b0101) begin
            bad++;
            $display("FAIL simul_press got=%b want=0101", pv);
        end
        key_n_in = 4'b1000;
        settle(4);
        #3;
        reset_reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs0 !== 24'h00000F) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=%h", obs0, 24'h00000F);
        end
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        pv = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL after_reset c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (c == 10) pv = key_press;
        end
        total++;
        if (pv !== 4'b0111) begin
            bad++;
            $display("FAIL after_reset_press got=%b want=0111", pv);
        end
        key_n_in = '1;
        settle(20);
    endtask

    task automatic test_no_repeat();
        int press_at = -1, npress = 0, nrpt = 0;
        key_n_nr = 4'b1110;
        for (int c = 0; c < 100; c++) begin
            tick();
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++;
                $display("FAIL no_repeat c=%0d got=%h want=%h", c, obs1, exp_vec(1));
            end
            if (nr_press[0]) begin
                npress++;
                press_at = c;
            end
            if (nr_repeat != '0) nrpt++;
        end
        total++;
        if (press_at !== 10 || npress !== 1 || nrpt !== 0) begin
            bad++;
            $display("FAIL no_repeat_summary press=%0d n=%0d rpt=%0d want=10,1,0", press_at, npress, nrpt);
        end
        key_n_nr = '1;
        settle(20);
    endtask

    task automatic test_random();
        int hold0[NK];
        int hold1[NK];
        int npress = 0;
        for (int k = 0; k < NK; k++) begin
            hold0[k] = 0;
            hold1[k] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold0[k] == 0) begin
                    key_n_in[k] = ~key_n_in[k];
                    hold0[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 90);
                end else hold0[k]--;
                if (hold1[k] == 0) begin
                    key_n_nr[k] = ~key_n_nr[k];
                    hold1[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 90);
                end else hold1[k]--;
            end
            tick();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++;
                $display("FAIL random c=%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++;
                $display("FAIL random_nr c=%0d got=%h want=%h", c, obs1, exp_vec(1));
            end
            npress += $countones(key_press);
        end
        total++;
        if (npress == 0) begin
            bad++;
            $display("FAIL random_activity got=0 presses want>0");
        end
        key_n_in = '1;
        key_n_nr = '1;
        settle(20);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold(2, 1'b0);
        test_hold(3, 1'b1);
        test_simul_reset();
        test_no_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
